// File: rtl/calc1_scheduler.sv
// calc1_scheduler: lets four two-cycle calc1 request ports share one non-pipelined ALU, granted round-robin.
// Latency: cmd in N, alu_valid in N+3, out_resp one cycle after alu_done; invalid cmd answered with out_resp=2 in N+2.
// Backpressure: none towards requesters; each port holds one request and drops commands while busy.
//
// Ports:
//   c_clk, reset[1:7]            clock, synchronous active-high reset (any bit)
//   reqN_cmd_in, reqN_data_in    request command / operand (op1 with cmd, op2 the cycle after)
//   out_respN, out_dataN         one-cycle response per port (0 = none)
//   alu_valid/cmd/op1/op2/tag    one-cycle issue to the shared ALU
//   alu_done/resp/data           ALU result strobe, at least one cycle after issue
module calc1_scheduler #(
    parameter int NPORT = 4,
    parameter int DW    = 32
) (
    input  logic          c_clk,
    input  logic [1:7]    reset,
    input  logic [0:3]    req1_cmd_in,
    input  logic [0:3]    req2_cmd_in,
    input  logic [0:3]    req3_cmd_in,
    input  logic [0:3]    req4_cmd_in,
    input  logic [0:DW-1] req1_data_in,
    input  logic [0:DW-1] req2_data_in,
    input  logic [0:DW-1] req3_data_in,
    input  logic [0:DW-1] req4_data_in,
    output logic [0:1]    out_resp1,
    output logic [0:1]    out_resp2,
    output logic [0:1]    out_resp3,
    output logic [0:1]    out_resp4,
    output logic [0:DW-1] out_data1,
    output logic [0:DW-1] out_data2,
    output logic [0:DW-1] out_data3,
    output logic [0:DW-1] out_data4,
    output logic          alu_valid,
    output logic [0:3]    alu_cmd,
    output logic [0:DW-1] alu_op1,
    output logic [0:DW-1] alu_op2,
    output logic [0:1]    alu_tag,
    input  logic          alu_done,
    input  logic [0:1]    alu_resp,
    input  logic [0:DW-1] alu_data
);

    // Per-port capture states
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_OP2  = 2'd1;
    localparam logic [1:0] C_PEND = 2'd2;

    // Scheduler states
    localparam logic [1:0] S_ARB   = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic rst;
    assign rst = |reset;

    logic [0:3]    cmd_in  [NPORT];
    logic [0:DW-1] data_in [NPORT];

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    logic [1:0]    cst_q   [NPORT];
    logic [1:0]    cst_d   [NPORT];
    logic [0:3]    cmd_q   [NPORT];
    logic [0:3]    cmd_d   [NPORT];
    logic [0:DW-1] op1_q   [NPORT];
    logic [0:DW-1] op1_d   [NPORT];
    logic [0:DW-1] op2_q   [NPORT];
    logic [0:DW-1] op2_d   [NPORT];
    logic [0:1]    resp_q  [NPORT];
    logic [0:1]    resp_d  [NPORT];
    logic [0:DW-1] rdata_q [NPORT];
    logic [0:DW-1] rdata_d [NPORT];

    logic [1:0] sst_q, sst_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] rr_q, rr_d;     // port index 0..3, i.e. port 1..4

    logic       found;
    logic [1:0] pick;
    logic [1:0] idx;

    function automatic logic cmd_ok(input logic [0:3] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    always_comb begin
        sst_d = sst_q;
        gnt_d = gnt_q;
        rr_d  = rr_q;
        found = 1'b0;
        pick  = rr_q;
        idx   = rr_q;
        for (int i = 0; i < NPORT; i++) begin
            cst_d[i]   = cst_q[i];
            cmd_d[i]   = cmd_q[i];
            op1_d[i]   = op1_q[i];
            op2_d[i]   = op2_q[i];
            resp_d[i]  = '0;
            rdata_d[i] = '0;
        end

        // Capture: commands arriving in OP2/PEND fall through untouched.
        for (int i = 0; i < NPORT; i++) begin
            case (cst_q[i])
                C_IDLE: begin
                    if (cmd_in[i] != '0) begin
                        cst_d[i] = C_OP2;
                        cmd_d[i] = cmd_in[i];
                        op1_d[i] = data_in[i];
                    end
                end
                C_OP2: begin
                    op2_d[i] = data_in[i];
                    if (cmd_ok(cmd_q[i])) begin
                        cst_d[i] = C_PEND;
                    end else begin
                        // Rejected locally: answer next cycle and free the port so
                        // it can take a new command in that same response cycle.
                        cst_d[i]  = C_IDLE;
                        resp_d[i] = 2'd2;
                    end
                end
                default: ;
            endcase
        end

        case (sst_q)
            S_ARB: begin
                // First pending port at or after rr_q, cyclically.
                for (int k = 0; k < NPORT; k++) begin
                    idx = rr_q + 2'(k);
                    if (!found && cst_q[idx] == C_PEND) begin
                        found = 1'b1;
                        pick  = idx;
                    end
                end
                if (found) begin
                    gnt_d = pick;
                    sst_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sst_d = S_WAIT;
                rr_d  = gnt_q + 2'd1;
            end
            S_WAIT: begin
                if (alu_done) begin
                    resp_d[gnt_q]  = (alu_resp == 2'd3) ? 2'd2 : alu_resp;
                    rdata_d[gnt_q] = alu_data;
                    // Port goes IDLE as its response becomes visible next cycle.
                    cst_d[gnt_q]   = C_IDLE;
                    sst_d          = S_ARB;
                end
            end
            default: sst_d = S_ARB;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (rst) begin
            sst_q <= S_ARB;
            gnt_q <= '0;
            rr_q  <= '0;
            for (int i = 0; i < NPORT; i++) begin
                cst_q[i]   <= C_IDLE;
                cmd_q[i]   <= '0;
                op1_q[i]   <= '0;
                op2_q[i]   <= '0;
                resp_q[i]  <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            sst_q <= sst_d;
            gnt_q <= gnt_d;
            rr_q  <= rr_d;
            for (int i = 0; i < NPORT; i++) begin
                cst_q[i]   <= cst_d[i];
                cmd_q[i]   <= cmd_d[i];
                op1_q[i]   <= op1_d[i];
                op2_q[i]   <= op2_d[i];
                resp_q[i]  <= resp_d[i];
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    assign alu_valid = (sst_q == S_ISSUE);
    assign alu_cmd   = alu_valid ? cmd_q[gnt_q] : '0;
    assign alu_op1   = alu_valid ? op1_q[gnt_q] : '0;
    assign alu_op2   = alu_valid ? op2_q[gnt_q] : '0;
    assign alu_tag   = alu_valid ? gnt_q : 2'b00;

    assign out_resp1 = resp_q[0];
    assign out_resp2 = resp_q[1];
    assign out_resp3 = resp_q[2];
    assign out_resp4 = resp_q[3];
    assign out_data1 = rdata_q[0];
    assign out_data2 = rdata_q[1];
    assign out_data3 = rdata_q[2];
    assign out_data4 = rdata_q[3];

endmodule

// File: tb/tb_calc1_scheduler.sv
// tb_calc1_scheduler: self-checking bench for calc1_scheduler with a behavioural ALU.
// Latency: drives inputs 1 time unit after the rising edge, samples on the falling edge.
// Backpressure: n/a (bench).
module tb_calc1_scheduler;

    logic c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    logic [1:7]  reset = 7'h7F;
    logic [3:0]  tb_cmd  [4];
    logic [31:0] tb_data [4];

    logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
    logic [31:0] out_data1, out_data2, out_data3, out_data4;
    logic        alu_valid;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_op1, alu_op2;
    logic [1:0]  alu_tag;
    logic        alu_done = 1'b0;
    logic [1:0]  alu_resp = 2'd0;
    logic [31:0] alu_data = 32'd0;

    logic [1:0]  o_resp [4];
    logic [31:0] o_data [4];
    assign o_resp[0] = out_resp1;
    assign o_resp[1] = out_resp2;
    assign o_resp[2] = out_resp3;
    assign o_resp[3] = out_resp4;
    assign o_data[0] = out_data1;
    assign o_data[1] = out_data2;
    assign o_data[2] = out_data3;
    assign o_data[3] = out_data4;

    calc1_scheduler #(.NPORT(4), .DW(32)) dut (
        .c_clk(c_clk), .reset(reset),
        .req1_cmd_in(tb_cmd[0]), .req2_cmd_in(tb_cmd[1]),
        .req3_cmd_in(tb_cmd[2]), .req4_cmd_in(tb_cmd[3]),
        .req1_data_in(tb_data[0]), .req2_data_in(tb_data[1]),
        .req3_data_in(tb_data[2]), .req4_data_in(tb_data[3]),
        .out_resp1(out_resp1), .out_resp2(out_resp2),
        .out_resp3(out_resp3), .out_resp4(out_resp4),
        .out_data1(out_data1), .out_data2(out_data2),
        .out_data3(out_data3), .out_data4(out_data4),
        .alu_valid(alu_valid), .alu_cmd(alu_cmd), .alu_op1(alu_op1),
        .alu_op2(alu_op2), .alu_tag(alu_tag),
        .alu_done(alu_done), .alu_resp(alu_resp), .alu_data(alu_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural ALU: result computed at issue, alu_done after alu_lat cycles.
    int          alu_lat    = 1;
    logic [1:0]  force_resp = 2'd0;   // 0 = answer success (1), else this code
    int          a_cnt      = 0;
    logic [1:0]  a_rsp      = 2'd0;
    logic [31:0] a_res      = 32'd0;

    function automatic logic [31:0] alu_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    always begin
        @(negedge c_clk);
        if (alu_valid) begin
            a_cnt = alu_lat;
            a_res = alu_calc(alu_cmd, alu_op1, alu_op2);
            a_rsp = (force_resp == 2'd0) ? 2'd1 : force_resp;
        end
        @(posedge c_clk);
        #1;
        alu_done = 1'b0;
        alu_resp = 2'd0;
        alu_data = 32'd0;
        if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 0) begin
                alu_done = 1'b1;
                alu_resp = a_rsp;
                alu_data = a_res;
            end
        end
    end

    task automatic quiet();
        for (int p = 0; p < 4; p++) begin
            tb_cmd[p]  = 4'd0;
            tb_data[p] = 32'd0;
        end
    endtask

    task automatic next_cycle();
        @(posedge c_clk);
        #1;
    endtask

    function automatic logic is_valid(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    function automatic logic [31:0] all_outs();
        return out_data1 | out_data2 | out_data3 | out_data4 | alu_op1 | alu_op2 |
               {30'd0, out_resp1} | {30'd0, out_resp2} | {30'd0, out_resp3} | {30'd0, out_resp4} |
               {31'd0, alu_valid} | {28'd0, alu_cmd} | {30'd0, alu_tag};
    endfunction

    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  frc;
        logic        issue;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    // One isolated transaction on an idle system, ALU latency 1.
    task automatic run_vec(input vec_t v, input int vi);
        int t_issue = -1, t_resp = -1, n_iss = 0, n_rsp = 0, n_oth = 0;
        logic [3:0]  g_cmd  = 4'd0;
        logic [31:0] g_op1  = 32'd0, g_op2 = 32'd0, g_data = 32'd0;
        logic [1:0]  g_tag  = 2'd0, g_resp = 2'd0;
        alu_lat    = 1;
        force_resp = v.frc;
        for (int k = 0; k < 9; k++) begin
            quiet();
            if (k == 0) begin
                tb_cmd[v.port]  = v.cmd;
                tb_data[v.port] = v.op1;
            end else if (k == 1) begin
                tb_data[v.port] = v.op2;
            end
            @(negedge c_clk);
            if (alu_valid) begin
                n_iss++; t_issue = k;
                g_cmd = alu_cmd; g_op1 = alu_op1; g_op2 = alu_op2; g_tag = alu_tag;
            end
            for (int p = 0; p < 4; p++) begin
                if (o_resp[p] != 2'd0) begin
                    if (p == v.port) begin
                        n_rsp++; t_resp = k; g_resp = o_resp[p]; g_data = o_data[p];
                    end else begin
                        n_oth++;
                    end
                end
            end
            next_cycle();
        end
        chk($sformatf("v%0d_issue_cnt", vi), n_iss, v.issue ? 1 : 0);
        if (v.issue) begin
            chk($sformatf("v%0d_issue_cycle", vi), t_issue, 3);
            chk($sformatf("v%0d_tag", vi), {30'd0, g_tag}, v.port);
            chk($sformatf("v%0d_alu_cmd", vi), {28'd0, g_cmd}, {28'd0, v.cmd});
            chk($sformatf("v%0d_alu_op1", vi), g_op1, v.op1);
            chk($sformatf("v%0d_alu_op2", vi), g_op2, v.op2);
        end
        chk($sformatf("v%0d_resp_cnt", vi), n_rsp, 1);
        chk($sformatf("v%0d_resp_cycle", vi), t_resp, v.issue ? 5 : 2);
        chk($sformatf("v%0d_resp", vi), {30'd0, g_resp}, {30'd0, v.exp_resp});
        chk($sformatf("v%0d_data", vi), g_data, v.exp_data);
        chk($sformatf("v%0d_other_ports", vi), n_oth, 0);
    endtask

    // All four ports request together; port 1 reissues in its own response cycle.
    task automatic seq_fairness();
        int tags[$];
        int rcnt[4] = '{0, 0, 0, 0};
        int exp_tags[5] = '{0, 1, 2, 3, 0};
        logic [1:0] r1_at5 = 2'd0;
        alu_lat = 1; force_resp = 2'd0;
        for (int k = 0; k < 22; k++) begin
            quiet();
            if (k == 0) for (int p = 0; p < 4; p++) begin
                tb_cmd[p] = 4'd1; tb_data[p] = 32'h100 * (p + 1);
            end
            if (k == 1) for (int p = 0; p < 4; p++) tb_data[p] = p + 1;
            if (k == 5) begin tb_cmd[0] = 4'd1; tb_data[0] = 32'h55; end
            if (k == 6) tb_data[0] = 32'h66;
            @(negedge c_clk);
            if (alu_valid) tags.push_back(int'(alu_tag));
            for (int p = 0; p < 4; p++) if (o_resp[p] != 2'd0) rcnt[p]++;
            if (k == 5) r1_at5 = out_resp1;
            next_cycle();
        end
        chk("fair_issue_cnt", tags.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fair_tag%0d", i), (tags.size() > i) ? tags[i] : 99, exp_tags[i]);
        chk("fair_p1_resp_same_cycle", {30'd0, r1_at5}, 1);
        chk("fair_p1_resp_cnt", rcnt[0], 2);
        chk("fair_p4_resp_cnt", rcnt[3], 1);
    endtask

    // Repeated commands on port 4 while busy must be dropped.
    task automatic seq_protocol();
        int n_iss = 0, n_rsp = 0;
        logic [31:0] g_op2 = 32'd0, g_data = 32'd0;
        alu_lat = 1; force_resp = 2'd0;
        for (int k = 0; k < 12; k++) begin
            quiet();
            if (k == 0) begin tb_cmd[3] = 4'd1; tb_data[3] = 32'd5; end
            if (k == 1) begin tb_cmd[3] = 4'd1; tb_data[3] = 32'd6; end
            if (k >= 2 && k <= 4) begin tb_cmd[3] = 4'd1; tb_data[3] = 32'd7; end
            @(negedge c_clk);
            if (alu_valid) begin n_iss++; g_op2 = alu_op2; end
            if (out_resp4 != 2'd0) begin n_rsp++; g_data = out_data4; end
            next_cycle();
        end
        chk("proto_issue_cnt", n_iss, 1);
        chk("proto_op2", g_op2, 32'd6);
        chk("proto_resp_cnt", n_rsp, 1);
        chk("proto_data", g_data, 32'd11);
    endtask

    // reset[1] pulsed while the ALU is busy; the late alu_done must be ignored.
    task automatic seq_reset_mid();
        int n_early = 0, t_iss = -1, t_rsp = -1;
        int tags[$];
        logic [31:0] outs_k5 = 32'hDEAD;
        alu_lat = 3; force_resp = 2'd0;
        for (int k = 0; k < 19; k++) begin
            quiet();
            reset = 7'd0;
            if (k == 0) begin tb_cmd[1] = 4'd1; tb_data[1] = 32'd3; end
            if (k == 1) tb_data[1] = 32'd4;
            if (k == 4) reset[1] = 1'b1;
            if (k == 8) begin
                alu_lat = 1;
                tb_cmd[0] = 4'd1; tb_data[0] = 32'h10;
                tb_cmd[3] = 4'd1; tb_data[3] = 32'h20;
            end
            if (k == 9) begin tb_data[0] = 32'd1; tb_data[3] = 32'd2; end
            @(negedge c_clk);
            if (k == 5) outs_k5 = all_outs();
            for (int p = 0; p < 4; p++) if (k < 8 && o_resp[p] != 2'd0) n_early++;
            if (alu_valid && k >= 8) begin
                tags.push_back(int'(alu_tag));
                if (t_iss < 0) t_iss = k;
            end
            if (out_resp1 != 2'd0 && t_rsp < 0) t_rsp = k;
            next_cycle();
        end
        chk("rstmid_outs_zero", outs_k5, 32'd0);
        chk("rstmid_no_resp", n_early, 0);
        chk("rstmid_issue_cycle", t_iss, 11);
        chk("rstmid_first_tag", (tags.size() > 0) ? tags[0] : 99, 0);
        chk("rstmid_second_tag", (tags.size() > 1) ? tags[1] : 99, 3);
        chk("rstmid_p1_resp_cycle", t_rsp, 13);
    endtask

    function automatic logic [3:0] pick_cmd(input int i);
        case (i)
            0: return 4'd1;  1: return 4'd2;  2: return 4'd5;  3: return 4'd6;
            4: return 4'd1;  5: return 4'd2;  6: return 4'd3;  7: return 4'd4;
            8: return 4'd7;  default: return 4'd15;
        endcase
    endfunction

    // Random traffic against a transaction-level model: each port holds at most one
    // request; the ALU serves eligible requests one at a time in cyclic port order.
    task automatic random_phase(input int ncyc);
        bit busy[4], op2_nx[4], outst[4], issued[4], exp_v[4];
        int elig[4], exp_c[4];
        logic [3:0]  rc[4];
        logic [31:0] r1[4], r2[4], exp_d[4];
        logic [1:0]  exp_r[4];
        int rr = 0, itag = 0, last_iss = -100, nbusy = 0, c, e, q;
        bit infl = 0, gen;
        for (int p = 0; p < 4; p++) begin
            busy[p] = 0; op2_nx[p] = 0; outst[p] = 0; issued[p] = 0; exp_v[p] = 0;
            elig[p] = 0; exp_c[p] = 0; rc[p] = 0; r1[p] = 0; r2[p] = 0; exp_d[p] = 0; exp_r[p] = 0;
        end
        for (int t = 0; t < ncyc + 300; t++) begin
            c   = cyc;
            gen = (t < ncyc);
            alu_lat    = 1 + int'($urandom % 4);
            force_resp = 2'($urandom % 4);
            for (int p = 0; p < 4; p++) begin
                tb_cmd[p]  = 4'd0;
                tb_data[p] = $urandom;
                if (op2_nx[p]) begin
                    tb_data[p] = r2[p];
                    if ($urandom % 3 == 0) tb_cmd[p] = 4'(1 + $urandom % 15);
                    op2_nx[p] = 0;
                end else if (!busy[p] && gen && ($urandom % 3 == 0)) begin
                    rc[p] = pick_cmd(int'($urandom % 10));
                    r1[p] = $urandom;
                    r2[p] = $urandom;
                    tb_cmd[p]  = rc[p];
                    tb_data[p] = r1[p];
                    busy[p] = 1; op2_nx[p] = 1;
                    if (is_valid(rc[p])) begin
                        outst[p] = 1; issued[p] = 0; elig[p] = c + 2;
                    end else begin
                        exp_v[p] = 1; exp_r[p] = 2'd2; exp_d[p] = 32'd0; exp_c[p] = c + 2;
                    end
                end
            end
            @(negedge c_clk);
            if (alu_valid) begin
                e = -1;
                for (int j = 0; j < 4; j++) begin
                    q = (rr + j) % 4;
                    if (e < 0 && outst[q] && !issued[q] && elig[q] <= c - 1) e = q;
                end
                if (e < 0) begin
                    chk("rnd_spurious_issue", 32'd1, 32'd0);
                end else begin
                    chk("rnd_tag", {30'd0, alu_tag}, e);
                    chk("rnd_alu_cmd", {28'd0, alu_cmd}, {28'd0, rc[e]});
                    chk("rnd_alu_op1", alu_op1, r1[e]);
                    chk("rnd_alu_op2", alu_op2, r2[e]);
                    chk("rnd_issue_gap", (c - last_iss) >= 3, 1);
                    chk("rnd_overlap", infl, 0);
                    issued[e] = 1; infl = 1; itag = e; rr = (e + 1) % 4; last_iss = c;
                end
            end else begin
                chk("rnd_alu_idle", {30'd0, alu_tag} | {28'd0, alu_cmd} | alu_op1 | alu_op2, 0);
            end
            if (alu_done && infl) begin
                exp_v[itag] = 1;
                exp_r[itag] = (alu_resp == 2'd3) ? 2'd2 : alu_resp;
                exp_d[itag] = alu_data;
                exp_c[itag] = c + 1;
                infl = 0;
            end
            for (int p = 0; p < 4; p++) begin
                if (exp_v[p] && exp_c[p] == c) begin
                    chk($sformatf("rnd_resp_p%0d", p + 1), {30'd0, o_resp[p]}, {30'd0, exp_r[p]});
                    chk($sformatf("rnd_data_p%0d", p + 1), o_data[p], exp_d[p]);
                    exp_v[p] = 0; busy[p] = 0; outst[p] = 0;
                end else begin
                    chk($sformatf("rnd_quiet_p%0d", p + 1), (o_resp[p] != 2'd0) || (o_data[p] != 32'd0), 0);
                end
            end
            next_cycle();
        end
        for (int p = 0; p < 4; p++) if (busy[p]) nbusy++;
        chk("rnd_drained", nbusy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{0, 4'd1,  32'h1,          32'h1FFF_FFFF, 2'd0, 1'b1, 2'd1, 32'h2000_0000};
        vecs[1] = '{1, 4'd3,  32'h1,          32'h0,         2'd0, 1'b0, 2'd2, 32'h0};
        vecs[2] = '{1, 4'd4,  32'h1,          32'h0,         2'd0, 1'b0, 2'd2, 32'h0};
        vecs[3] = '{2, 4'd2,  32'h1,          32'hF,         2'd2, 1'b1, 2'd2, 32'hFFFF_FFF2};
        vecs[4] = '{2, 4'd2,  32'h10,         32'h3,         2'd3, 1'b1, 2'd2, 32'hD};
        vecs[5] = '{3, 4'd5,  32'h1,          32'h4,         2'd0, 1'b1, 2'd1, 32'h10};
        vecs[6] = '{0, 4'd6,  32'h8000_0000,  32'd31,        2'd0, 1'b1, 2'd1, 32'h1};
        vecs[7] = '{3, 4'd15, 32'h1234,       32'h5678,      2'd0, 1'b0, 2'd2, 32'h0};
        vecs[8] = '{3, 4'd1,  32'hFFFF_FFFF,  32'h1,         2'd2, 1'b1, 2'd2, 32'h0};

        quiet();
        reset = 7'h7F;
        repeat (3) @(posedge c_clk);
        #1;
        @(negedge c_clk);
        chk("reset_outputs", all_outs(), 32'd0);
        next_cycle();
        reset = 7'd0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);
        seq_fairness();
        seq_protocol();
        seq_reset_mid();
        random_phase(2500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc1_scheduler.md
# calc1_scheduler

Front-end scheduler that lets the four calc1 request ports share one non-pipelined arithmetic unit. It captures each port's two-cycle request (command plus operand 1, then operand 2) and holds it as pending. It grants pending requests round-robin to the ALU and routes each result back to the originating port's response bus. Invalid commands are rejected locally and never reach the ALU.

## Interface
All vectors are MSB-first: `[0:N-1]`, bit 0 is the MSB.
- `NPORT`, default 4: number of requester ports. Fixed at 4.
- `DW`, default 32: data width.
- `c_clk`, in, 1: clock. All logic on rising edge.
- `reset`, in, `[1:7]`: synchronous, active-high. Any bit high resets the block.
- `reqN_cmd_in`, in, `[0:3]`, N=1..4: command. 0 = no-op, 1 = add, 2 = sub, 5 = shift left, 6 = shift right.
- `reqN_data_in`, in, `[0:31]`, N=1..4: operand 1 in the command cycle, operand 2 in the following cycle.
- `out_respN`, out, `[0:1]`, N=1..4: response. 0 = none, 1 = success, 2 = overflow/underflow/invalid, 3 = reserved (never driven).
- `out_dataN`, out, `[0:31]`, N=1..4: result, valid only while `out_respN`≠0.
- `alu_valid`, out, 1: one-cycle issue strobe.
- `alu_cmd`, out, `[0:3]`: granted command.
- `alu_op1` and `alu_op2`, out, `[0:31]` each: granted operands.
- `alu_tag`, out, `[0:1]`: granted port, 0..3 for ports 1..4.
- `alu_done`, in, 1: result strobe. Arrives ≥1 cycle after `alu_valid`.
- `alu_resp`, in, `[0:1]`: ALU response code.
- `alu_data`, in, `[0:31]`: ALU result.

## Operation
- **Per-port capture FSM**
  - States: IDLE, OP2, PEND.
  - IDLE → OP2 when `cmd`≠0; latch cmd and operand 1.
  - OP2 → PEND next cycle unconditionally; latch `data` as operand 2 and ignore `cmd`.
  - PEND → IDLE when the port's response is presented.
  - A nonzero `cmd` while in OP2 or PEND is a protocol violation. It is ignored and not queued.
- **Invalid commands** (cmd ∉ {1,2,5,6})
  - Captured normally.
  - On entering PEND, the port presents `resp`=2, `data`=0 the next cycle and returns to IDLE.
  - The request never enters arbitration.
- **Scheduler FSM**
  - States: ARB, ISSUE, WAIT.
  - ARB: if any valid PEND port, grant the first such port at or after `rr_ptr` (cyclic 1→2→3→4→1). Register the grant and go to ISSUE. Otherwise stay in ARB.
  - ISSUE: drive `alu_valid`=1 with the granted cmd, operands and tag for exactly one cycle; then go to WAIT. Set `rr_ptr` to grant+1 (4 wraps to 1).
  - WAIT: on `alu_done`, register `alu_resp` and `alu_data` to the granted port's outputs for the next cycle, then go to ARB.
  - `alu_resp`=3 is forwarded as 2.
- **Outputs**
  - Every `out_respN`/`out_dataN` is 0 except in its single response cycle.
  - When not in ISSUE, the `alu_*` outputs are 0.
- Arithmetic is performed entirely by the ALU; the scheduler never modifies operands or results.
- `alu_done` outside WAIT is ignored.

## Timing
- Reset: all capture FSMs → IDLE, scheduler → ARB, `rr_ptr`=1. All outputs read 0 in the cycle after reset is sampled.
- Reset mid-operation discards all pending and in-flight requests. A later `alu_done` for them is ignored.
- Request cycle convention: command in cycle N, operand 2 in N+1, PEND from N+2.
- Idle-system latency:
  - grant registered at the end of N+2;
  - `alu_valid` in N+3;
  - earliest `alu_done` in N+4;
  - `out_resp` in N+5.
- Invalid command: `out_resp`=2 in cycle N+2.
- A port may present a new command in the same cycle its response is driven.
- Simultaneous PEND on several ports: one grant per ARB pass, round-robin. No port waits more than 3 other grants.
- Throughput: at most one ALU operation in flight. Back-to-back issues are ≥3 cycles apart (ARB, ISSUE, ≥1 WAIT).

## Test plan
- **Single add:** port 1, cmd 1, op1=1, op2=0x1FFF_FFFF; ALU model with 1-cycle latency returns resp 1 → `alu_valid` at N+3 (tag 0), `out_resp1`=1 and `out_data1`=0x2000_0000 at N+5 for one cycle; all other ports 0.
- **Invalid commands:** port 2, cmd 3, then cmd 4, op1=1 → `out_resp2`=2, `out_data2`=0 at N+2; `alu_valid` never asserted.
- **Fairness:** all four ports issue cmd 1 in the same cycle with distinct operands → ALU tags 0, 1, 2, 3 in order. Immediately reissue from port 1 → port 1 is served after port 4, not before.
- **Error forward:** port 3, cmd 2, op1=1, op2=0xF; ALU returns resp 2 → `out_resp3`=2. ALU returns resp 3 on a later op → `out_resp3`=2.
- **Protocol violation:** port 4 issues cmd 1, then cmd 1 again while in PEND → exactly one ALU issue and one response.
- **Reset mid-operation:** during WAIT, assert `reset[1]` for 1 cycle, then `alu_done` → no `out_resp` asserted, `rr_ptr`=1, and a fresh request is served with nominal latency.
